// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential matrix-vector multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Ceiling log2, returns at least 1 so counters never collapse to zero width.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Result width: full product plus headroom for summing ndata products.
    function automatic int unsigned accw_f(input int unsigned nbits, input int unsigned ndata);
        return 2 * nbits + clog2_f(ndata);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: acc += a*b each enabled cycle, signed or unsigned.
module mac_lane
    import matmul_pkg::*;
#(
    parameter int unsigned Nbits  = 8,
    parameter int unsigned ACCW   = 18,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [Nbits-1:0] a,
    input  logic [Nbits-1:0] b,
    output logic [ACCW-1:0]  acc
);

    logic signed [Nbits:0]     a_e;
    logic signed [Nbits:0]     b_e;
    logic signed [2*Nbits+1:0] prod;
    logic        [ACCW-1:0]    prod_x;

    // One extra operand bit lets a single signed multiplier serve both modes.
    always_comb begin
        a_e    = {SIGNED & a[Nbits-1], a};
        b_e    = {SIGNED & b[Nbits-1], b};
        prod   = a_e * b_e;
        prod_x = ACCW'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + prod_x;
        end
    end

endmodule

// File: rtl/mult_mat_vec_seq.sv
// Sequential matrix-vector multiply: one column per cycle, one MAC lane per row.
module mult_mat_vec_seq
    import matmul_pkg::*;
#(
    parameter int unsigned  Mdata  = 4,
    parameter int unsigned  Ndata  = 4,
    parameter int unsigned  Nbits  = 8,
    parameter bit           SIGNED = 1'b0,
    localparam int unsigned ACCW   = accw_f(Nbits, Ndata)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [Mdata*Ndata*Nbits-1:0] M,
    input  logic [Ndata*Nbits-1:0]       X,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [Mdata*ACCW-1:0]        out,
    output logic                         busy
);

    localparam int unsigned KW = clog2_f(Ndata);

    state_t                       state;
    state_t                       state_nxt;
    logic [KW-1:0]                k;
    logic                         load_c;
    logic                         step_c;
    logic [Mdata*Ndata*Nbits-1:0] m_q;
    logic [Ndata*Nbits-1:0]       x_q;
    logic [Nbits-1:0]             x_k;

    assign x_k = x_q[k*Nbits +: Nbits];

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    load_c    = 1'b1;
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                step_c = 1'b1;
                if (k == KW'(Ndata - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k         <= '0;
            m_q       <= '0;
            x_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_DONE);
            busy      <= (state_nxt != ST_IDLE);
            if (load_c) begin
                m_q <= M;
                x_q <= X;
                k   <= '0;
            end else if (step_c) begin
                k <= KW'(k + 1'b1);
            end
        end
    end

    for (genvar i = 0; i < Mdata; i++) begin : g_lane
        mac_lane #(
            .Nbits  (Nbits),
            .ACCW   (ACCW),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (load_c),
            .enable (step_c),
            .a      (m_q[i*Ndata*Nbits + k*Nbits +: Nbits]),
            .b      (x_k),
            .acc    (out[i*ACCW +: ACCW])
        );
    end

endmodule

// File: tb/tb_mult_mat_vec_seq.sv
// Scoreboard bench: unsigned and signed instances share stimulus; a negedge monitor checks results.
module tb_mult_mat_vec_seq;

    localparam int unsigned MD = 4;
    localparam int unsigned ND = 4;
    localparam int unsigned NB = 8;
    localparam int unsigned AW = 18;
    localparam int unsigned MW = MD * AW;
    localparam int unsigned MATW = MD * ND * NB;
    localparam int unsigned VECW = ND * NB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [MATW-1:0] m;
    logic [VECW-1:0] x;

    logic [MW-1:0] outv [2];
    logic          ov   [2];
    logic          ir   [2];
    logic          bz   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;

    logic [MW-1:0] q_u [$];
    logic [MW-1:0] q_s [$];
    logic [MW-1:0] held [2];
    logic [MW-1:0] last [2];
    logic          pov  [2];

    mult_mat_vec_seq #(.Mdata(MD), .Ndata(ND), .Nbits(NB), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .M(m), .X(x), .out_valid(ov[0]), .out_ready(out_ready), .out(outv[0]), .busy(bz[0])
    );

    mult_mat_vec_seq #(.Mdata(MD), .Ndata(ND), .Nbits(NB), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .M(m), .X(x), .out_valid(ov[1]), .out_ready(out_ready), .out(outv[1]), .busy(bz[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? q_u.size() : q_s.size();
    endfunction

    function automatic logic [MW-1:0] sb_pop(input int d);
        if (d == 0) return q_u.pop_front();
        return q_s.pop_front();
    endfunction

    // Monitor: results, hold-while-stalled, latency and idle output value.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (ov[d]) begin
                    if (!pov[d]) chk("latency", d, MW'(cyc - acc_cyc), MW'(ND));
                    else         chk("hold_out", d, outv[d], held[d]);
                    chk("in_ready_in_done", d, MW'(ir[d]), MW'(0));
                    chk("busy_in_done", d, MW'(bz[d]), MW'(1));
                    held[d] = outv[d];
                    if (out_ready) begin
                        if (sb_size(d) == 0) begin
                            chk("unexpected_result", d, outv[d], ~outv[d]);
                        end else begin
                            last[d] = sb_pop(d);
                            chk("result", d, outv[d], last[d]);
                        end
                    end
                end else if (ir[d]) begin
                    chk("idle_out", d, outv[d], last[d]);
                    chk("busy_in_idle", d, MW'(bz[d]), MW'(0));
                end
                pov[d] = ov[d];
            end
        end
    end

    function automatic logic [MATW-1:0] mat_fill(input logic [NB-1:0] v);
        return {(MD*ND){v}};
    endfunction

    function automatic logic [MATW-1:0] mat_ident();
        logic [MATW-1:0] r;
        r = '0;
        for (int i = 0; i < MD; i++) r[(i*ND + i)*NB +: NB] = NB'(1);
        return r;
    endfunction

    function automatic logic [MATW-1:0] mat_row0(input logic [NB-1:0] v);
        logic [MATW-1:0] r;
        r = '0;
        r[0 +: ND*NB] = {ND{v}};
        return r;
    endfunction

    function automatic logic [VECW-1:0] vec4(input int a, input int b, input int c, input int e);
        return {NB'(e), NB'(c), NB'(b), NB'(a)};
    endfunction

    function automatic logic [MW-1:0] exp4(input int a, input int b, input int c, input int e);
        return {AW'(e), AW'(c), AW'(b), AW'(a)};
    endfunction

    // Offer one operand set; expectations are queued before the accept edge.
    task automatic send(input logic [MATW-1:0] mat, input logic [VECW-1:0] vec,
                        input logic [MW-1:0] eu, input logic [MW-1:0] es, input bit scramble);
        int n;
        @(posedge clk); #1;
        m = mat; x = vec; in_valid = 1'b1;
        n = 0;
        while (!ir[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 0, MW'(ir[0]), MW'(1));
            in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        q_u.push_back(eu);
        q_s.push_back(es);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (scramble) begin
            m = ~mat;
            x = ~vec;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_u.size() != 0 || q_s.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            chk("drain_timeout", 0, MW'(q_u.size() + q_s.size()), MW'(0));
            q_u.delete();
            q_s.delete();
        end
        @(posedge clk); #1;
    endtask

    // Called just after a posedge; asserts reset mid-cycle and checks forced values.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out", d, outv[d], MW'(0));
            chk("rst_out_valid", d, MW'(ov[d]), MW'(0));
            chk("rst_busy", d, MW'(bz[d]), MW'(0));
            chk("rst_in_ready", d, MW'(ir[d]), MW'(1));
            last[d] = '0;
            held[d] = '0;
            pov[d]  = 1'b0;
        end
        q_u.delete();
        q_s.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; m = '0; x = '0;
        for (int d = 0; d < 2; d++) begin
            last[d] = '0; held[d] = '0; pov[d] = 1'b0;
        end
        @(posedge clk);
        do_reset();

        send(mat_ident(), vec4(1, 2, 3, 4), exp4(1, 2, 3, 4), exp4(1, 2, 3, 4), 1'b0);
        drain();
        send(mat_fill(8'hFF), {ND{8'hFF}}, exp4(260100, 260100, 260100, 260100), exp4(4, 4, 4, 4), 1'b0);
        drain();
        send(mat_fill(8'h80), {ND{8'h80}}, exp4(65536, 65536, 65536, 65536),
             exp4(65536, 65536, 65536, 65536), 1'b0);
        drain();
        send(mat_row0(8'h01), {ND{8'hFF}}, exp4(1020, 0, 0, 0), exp4(-4, 0, 0, 0), 1'b0);
        drain();
        send({MD{8'hFD, 8'h02, 8'hFD, 8'h02}}, vec4(10, 20, 30, 40),
             exp4(15260, 15260, 15260, 15260), exp4(-100, -100, -100, -100), 1'b0);
        drain();

        // Consumer stall with a competing operand set offered throughout.
        out_ready = 1'b0;
        send(mat_fill(8'd3), vec4(1, 2, 3, 4), exp4(30, 30, 30, 30), exp4(30, 30, 30, 30), 1'b0);
        m = mat_fill(8'd7); x = {ND{8'd7}}; in_valid = 1'b1;
        repeat (ND + 10) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        send(mat_ident(), vec4(5, 6, 7, 8), exp4(5, 6, 7, 8), exp4(5, 6, 7, 8), 1'b1);
        drain();

        // Abort mid-computation at k=2, then a clean operation.
        send(mat_fill(8'hFF), {ND{8'hFF}}, exp4(260100, 260100, 260100, 260100), exp4(4, 4, 4, 4), 1'b0);
        repeat (2) @(posedge clk);
        do_reset();
        repeat (ND + 2) begin
            @(posedge clk); #1;
        end
        send(mat_ident(), vec4(1, 2, 3, 4), exp4(1, 2, 3, 4), exp4(1, 2, 3, 4), 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_mat_vec_seq.md
MULT_MAT_VEC_SEQ -- requirements
Module: mult_mat_vec_seq

Interface
REQ-001 SHALL have parameter Mdata, default 4, number of matrix rows / output elements.
REQ-002 SHALL have parameter Ndata, default 4, number of matrix columns / vector elements (>=2).
REQ-003 SHALL have parameter Nbits, default 8, operand element width.
REQ-004 SHALL have parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 SHALL define derived constant ACCW = 2*Nbits + clog2(Ndata), the result element width.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port in_valid  input  1  operand set offered.
REQ-009 SHALL have port in_ready  output  1  block accepts an operand set.
REQ-010 SHALL have port M  input  Mdata*Ndata*Nbits  matrix; row i at bits [(i+1)*Ndata*Nbits-1 : i*Ndata*Nbits]; element j of a row at row offset j*Nbits.
REQ-011 SHALL have port X  input  Ndata*Nbits  vector; element j at [(j+1)*Nbits-1 : j*Nbits].
REQ-012 SHALL have port out_valid  output  1  result held on out.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port out  output  Mdata*ACCW  result; element i at [(i+1)*ACCW-1 : i*ACCW].
REQ-015 SHALL have port busy  output  1  high in COMPUTE or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-017 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-018 SHALL, on an edge in IDLE with in_valid high, register M and X, clear all Mdata accumulators, set column counter k=0, and enter COMPUTE.
REQ-019 SHALL, on each COMPUTE edge, add M[i][k]*X[k] to accumulator i for every row i in parallel (Mdata multipliers, one column per cycle) and increment k.
REQ-020 SHALL enter DONE on the COMPUTE edge where k = Ndata-1 is processed; out_valid therefore rises exactly Ndata edges after the accept edge.
REQ-021 SHALL hold out and out_valid stable in DONE until out_ready is high, then return to IDLE on that edge.
REQ-022 SHALL ignore in_valid, M and X outside IDLE; input changes after the accept edge SHALL NOT affect the result.
REQ-023 SHALL, with SIGNED=1, sign-extend products to ACCW bits and accumulate in two's complement; with SIGNED=0, zero-extend.
REQ-024 SHALL never overflow: ACCW covers Ndata worst-case products in both modes.
REQ-025 SHALL drive out from the accumulator registers; out is undefined-free (equals last computed result) in IDLE after a transfer.

Reset
REQ-026 SHALL, on rst_n low at any time, including mid-COMPUTE or in DONE, asynchronously force state IDLE, k=0, accumulators and out to 0, out_valid 0, busy 0; in_ready SHALL be 1 after reset deasserts.
REQ-027 SHALL discard any in-flight operation on reset; no partial result is ever presented.

Structure
REQ-028 SHALL take the FSM state typedef and the clog2-based ACCW width function from shared package matmul_pkg.
REQ-029 SHALL instantiate one sub-module mac_lane (Nbits, ACCW, SIGNED parameters; clear, enable, a, b inputs; acc output) per row via a generate loop.

Verification
REQ-030 SHALL cover: identity M, X=[1,2,3,4], SIGNED=0 -> out=[1,2,3,4], out_valid 4 edges after accept.
REQ-031 SHALL cover: all M,X = 255, SIGNED=0 -> every out element = 260100.
REQ-032 SHALL cover: all M,X = -128 (0x80), SIGNED=1 -> every out element = 65536; M row0 all 1, X all -1 -> out[0] = -4.
REQ-033 SHALL cover: out_ready held low 10 cycles in DONE -> out stable, in_ready low, new in_valid ignored; result transferred on first out_ready high edge.
REQ-034 SHALL cover: M/X changed on cycle after accept -> result matches originally accepted operands.
REQ-035 SHALL cover: rst_n pulsed low at k=2 -> out=0, out_valid=0, IDLE; next operand set computes correctly.
